soc_ram_arbiter: RTL

Two-port Avalon-MM arbiter that shares the single-port on-chip CPU RAM (15000 × 32-bit, 14-bit word address, byte enables, unregistered output) between the Nios CPU data master and the video-pipeline descriptor DMA. It sits directly in front of the RAM's write/read port. It provides round-robin arbitration, burst sequencing with incrementing addresses, and fixed one-cycle read latency back to each requester.

---
 rtl/soc_ram_arb_pkg.sv | 28 ++
 rtl/soc_ram_arb_if.sv | 31 +++
 rtl/soc_ram_arb_rr.sv | 33 +++
 rtl/soc_ram_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/soc_ram_arb_pkg.sv
// Shared types and defaults for the two-port CPU RAM arbiter.
// Build option: SOC_RAM_ARB_RANGE_CHECK_EN enables the out-of-range beat check.
package soc_ram_arb_pkg;

  localparam int AW_DEF        = 14;
  localparam int DW_DEF        = 32;
  localparam int MAX_BURST_DEF = 8;
  localparam int DEPTH_DEF     = 15000;
  localparam int BCW           = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST
  } arb_state_e;

  // 0 = CPU data master, 1 = video descriptor DMA
  typedef logic port_id_t;

  // A burstcount of 0 counts as a single beat; oversize requests are clamped.
  function automatic logic [BCW-1:0] eff_burst(input logic [BCW-1:0] bc,
                                               input logic [BCW-1:0] max_bc);
    if (bc == '0) return BCW'(1);
    if (bc > max_bc) return max_bc;
    return bc;
  endfunction

endpackage

// File: rtl/soc_ram_arb_if.sv
// Avalon-MM requester bundle for one arbiter port.
// Build option: SOC_RAM_ARB_RANGE_CHECK_EN (addr_err is only live with it).
interface soc_ram_arb_if
  import soc_ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic [AW-1:0]   address;
  logic            read;
  logic            write;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0]   writedata;
  logic [BCW-1:0]  burstcount;
  logic            waitrequest;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;
  logic            addr_err;

  modport master (
    output address, read, write, byteenable, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid, addr_err
  );

  modport slave (
    input  address, read, write, byteenable, writedata, burstcount,
    output waitrequest, readdata, readdatavalid, addr_err
  );

endinterface

// File: rtl/soc_ram_arb_rr.sv
// Two-way round-robin grant; on a tie the port that did not win last time goes.
// Build option: none (SOC_RAM_ARB_RANGE_CHECK_EN is handled in the top).
module soc_ram_arb_rr
  import soc_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output port_id_t   sel
);

  port_id_t last_grant;

  always_comb begin
    sel = 1'b0;
    case (req)
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant;
      default: sel = 1'b0;
    endcase
    gnt = 2'b00;
    if (req != 2'b00) gnt[sel] = 1'b1;
  end

  // Resets to port 1 so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_grant <= 1'b1;
    else if (accept) last_grant <= sel;
  end

endmodule

// File: rtl/soc_ram_arbiter.sv
// Shares the single-port CPU RAM between the Nios data master (p0) and the DMA (p1).
// Build option: define SOC_RAM_ARB_RANGE_CHECK_EN to block beats at addresses >= DEPTH.
module soc_ram_arbiter
  import soc_ram_arb_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  soc_ram_arb_if.slave    p0,
  soc_ram_arb_if.slave    p1,
  output logic [AW-1:0]   ram_address,
  output logic [DW/8-1:0] ram_byteenable,
  output logic [DW-1:0]   ram_writedata,
  output logic            ram_chipselect,
  output logic            ram_write,
  input  logic [DW-1:0]   ram_readdata
);

`ifdef SOC_RAM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  arb_state_e         state;
  port_id_t           bport, sel, cur;
  logic [AW-1:0]      baddr, cur_addr;
  logic [BCW-1:0]     bcnt, bl;
  logic               live, accept, beat, beat_rd, wr, oor;
  logic [1:0]         req, gnt, wreq, rdv;
  logic               rd_vld_q, rd_zero_q;
  port_id_t           rd_port_q;
  logic [1:0][DW-1:0] hold_q;
  logic [DW-1:0]      ret_data;

  // live keeps every port stalled while reset is asserted and on the release edge.
  assign req = (live && state == IDLE) ? {p1.read | p1.write, p0.read | p0.write} : 2'b00;

  soc_ram_arb_rr u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .accept  (accept),
    .gnt     (gnt),
    .sel     (sel)
  );

  assign accept = |gnt;
  assign bl     = eff_burst(sel ? p1.burstcount : p0.burstcount, BCW'(MAX_BURST));

  always_comb begin
    cur      = bport;
    cur_addr = baddr;
    beat     = 1'b0;
    beat_rd  = 1'b0;
    wr       = 1'b0;
    wreq     = 2'b11;
    case (state)
      IDLE: if (accept) begin
        cur      = sel;
        cur_addr = sel ? p1.address : p0.address;
        beat     = 1'b1;
        beat_rd  = sel ? p1.read : p0.read;
        wr       = ~beat_rd;
        wreq     = ~gnt;
      end
      RD_BURST: begin
        beat    = 1'b1;
        beat_rd = 1'b1;
      end
      // Owner keeps the grant until all beats land; a stalled master is simply waited on.
      WR_BURST: begin
        wreq[bport] = 1'b0;
        wr          = bport ? p1.write : p0.write;
        beat        = wr;
      end
      default: ;
    endcase
  end

  assign oor = RANGE_EN && beat && ({1'b0, cur_addr} >= DEPTH_W);

  assign ram_address    = cur_addr;
  assign ram_byteenable = cur ? p1.byteenable : p0.byteenable;
  assign ram_writedata  = cur ? p1.writedata  : p0.writedata;
  assign ram_chipselect = beat & ~oor;
  assign ram_write      = wr & ~oor;

  assign p0.waitrequest = wreq[0];
  assign p1.waitrequest = wreq[1];
  assign p0.addr_err    = oor & ~cur;
  assign p1.addr_err    = oor &  cur;

  // RAM q lines up with the tag registered on the address cycle.
  assign ret_data = rd_zero_q ? '0 : ram_readdata;
  assign rdv      = {rd_vld_q & rd_port_q, rd_vld_q & ~rd_port_q};

  assign p0.readdatavalid = rdv[0];
  assign p1.readdatavalid = rdv[1];
  assign p0.readdata      = rdv[0] ? ret_data : hold_q[0];
  assign p1.readdata      = rdv[1] ? ret_data : hold_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bport     <= 1'b0;
      baddr     <= '0;
      bcnt      <= '0;
      live      <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_port_q <= 1'b0;
      rd_zero_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      live      <= 1'b1;
      rd_vld_q  <= beat_rd;
      rd_port_q <= cur;
      rd_zero_q <= oor;
      for (int i = 0; i < 2; i++)
        if (rdv[i]) hold_q[i] <= ret_data;
      case (state)
        IDLE: if (accept) begin
          bport <= sel;
          baddr <= cur_addr + AW'(1);
          bcnt  <= bl - BCW'(1);
          if (bl > BCW'(1)) state <= beat_rd ? RD_BURST : WR_BURST;
        end
        RD_BURST: begin
          baddr <= baddr + AW'(1);
          bcnt  <= bcnt - BCW'(1);
          if (bcnt == BCW'(1)) state <= IDLE;
        end
        WR_BURST: if (wr) begin
          baddr <= baddr + AW'(1);
          bcnt  <= bcnt - BCW'(1);
          if (bcnt == BCW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
